// File: rtl/spi_slave_controller.sv
// SPI responder (mode 0, standard/quad) bridging command/address/data
// phases from an external master onto 32-bit valid/ready streams.
module spi_slave_controller #(
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic        spi_sdo0,
    output logic        spi_sdo1,
    output logic        spi_sdo2,
    output logic        spi_sdo3,
    output logic [3:0]  spi_oe,
    output logic [7:0]  cmd,
    output logic [31:0] rx_addr,
    output logic        rx_addr_valid,
    output logic [31:0] rx_data,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    input  logic [31:0] tx_data,
    input  logic        tx_data_valid,
    output logic        tx_data_ready,
    output logic        eot,
    output logic        busy,
    output logic        overflow,
    output logic        underflow,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA_RX, DATA_TX, IGNORE
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h02;
    localparam logic [7:0] CMD_QWR = 8'h32;
    localparam logic [7:0] CMD_RD  = 8'h03;
    localparam logic [7:0] CMD_QRD = 8'h6B;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic [1:0]  sclk_sy;
    logic        sclk_d;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [1:0]  csn_sy;
    logic        csn_d;
    logic        csn_rise;
    logic        csn_s;
    logic [3:0]  sdi_m;
    logic [3:0]  sdi_s;
    logic [1:0]  prime_cnt;
    logic        primed;
    logic        armed;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [30:0] sh;
    logic [31:0] tx_sh;
    logic        is_wr;
    logic        is_quad;
    logic [3:0]  sdo;

    logic [7:0]  cmd_word;
    logic [31:0] addr_word;
    logic [31:0] rx_word;
    logic        word_last;
    logic        dec_ok;
    logic        dec_wr;
    logic        dec_quad;
    logic        tx_fetch;

    assign csn_s  = csn_sy[1];
    assign primed = prime_cnt[1];
    assign busy   = (state != IDLE);
    assign {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0} = sdo;

    assign cmd_word  = {sh[6:0], sdi_s[0]};
    assign addr_word = {sh, sdi_s[0]};
    assign rx_word   = is_quad ? {sh[27:0], sdi_s} : {sh, sdi_s[0]};
    assign word_last = is_quad ? (cnt == 8'd7) : (cnt == 8'd31);

    always_comb begin
        dec_ok   = 1'b0;
        dec_wr   = 1'b0;
        dec_quad = 1'b0;
        unique case (1'b1)
            (cmd_word == CMD_WR): begin
                dec_ok = 1'b1;
                dec_wr = 1'b1;
            end
            (cmd_word == CMD_QWR): begin
                dec_ok   = 1'b1;
                dec_wr   = 1'b1;
                dec_quad = 1'b1;
            end
            (cmd_word == CMD_RD): begin
                dec_ok = 1'b1;
            end
            (cmd_word == CMD_QRD): begin
                dec_ok   = 1'b1;
                dec_quad = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                // After reset, a csn already low is not a valid frame start
                if (primed && !csn_s)
                    state_nx = armed ? CMD : IGNORE;
            end
            CMD: begin
                if (sclk_rise && cnt == 8'd7)
                    state_nx = dec_ok ? ADDR : IGNORE;
            end
            ADDR: begin
                if (sclk_rise && cnt == 8'd31) begin
                    if (is_wr)
                        state_nx = DATA_RX;
                    else if (DUMMY_CYCLES > 0)
                        state_nx = DUMMY;
                    else
                        state_nx = DATA_TX;
                end
            end
            DUMMY: begin
                if (sclk_rise && cnt == DUMMY_LAST)
                    state_nx = DATA_TX;
            end
            default: ;
        endcase
        if (csn_rise)
            state_nx = IDLE;
    end

    always_comb begin
        tx_fetch = 1'b0;
        if (state_nx == DATA_TX && state != DATA_TX)
            tx_fetch = 1'b1;
        if (state == DATA_TX && sclk_rise && word_last && !csn_rise)
            tx_fetch = 1'b1;
    end

    always_comb begin
        spi_oe = 4'b0000;
        if (state == DATA_TX)
            spi_oe = is_quad ? 4'b1111 : 4'b0010;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sy   <= 2'b00;
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csn_sy    <= 2'b11;
            csn_d     <= 1'b1;
            csn_rise  <= 1'b0;
            sdi_m     <= 4'h0;
            sdi_s     <= 4'h0;
            prime_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            sclk_sy   <= {sclk_sy[0], spi_sclk};
            sclk_d    <= sclk_sy[1];
            sclk_rise <= sclk_sy[1] & ~sclk_d;
            sclk_fall <= ~sclk_sy[1] & sclk_d;
            csn_sy    <= {csn_sy[0], spi_csn};
            csn_d     <= csn_sy[1];
            csn_rise  <= csn_sy[1] & ~csn_d;
            sdi_m     <= {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0};
            sdi_s     <= sdi_m;
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
            armed <= armed | (primed & csn_s);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            sh            <= '0;
            tx_sh         <= '0;
            is_wr         <= 1'b0;
            is_quad       <= 1'b0;
            sdo           <= 4'h0;
            cmd           <= 8'h00;
            rx_addr       <= '0;
            rx_addr_valid <= 1'b0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            tx_data_ready <= 1'b0;
            eot           <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            state         <= state_nx;
            rx_addr_valid <= 1'b0;
            eot           <= csn_rise;
            tx_data_ready <= tx_fetch;
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (rx_data_valid && rx_data_ready)
                rx_data_valid <= 1'b0;

            if (csn_rise) begin
                cnt <= 8'd0;
                sdo <= 4'h0;
            end else begin
                unique case (state)
                    CMD, ADDR: begin
                        if (sclk_rise) begin
                            sh  <= {sh[29:0], sdi_s[0]};
                            cnt <= cnt + 8'd1;
                            if (state == CMD && cnt == 8'd7) begin
                                cnt     <= 8'd0;
                                cmd     <= cmd_word;
                                is_wr   <= dec_wr;
                                is_quad <= dec_quad;
                            end
                            if (state == ADDR && cnt == 8'd31) begin
                                cnt           <= 8'd0;
                                rx_addr       <= addr_word;
                                rx_addr_valid <= 1'b1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise)
                            cnt <= (cnt == DUMMY_LAST) ? 8'd0 : cnt + 8'd1;
                    end
                    DATA_RX: begin
                        if (sclk_rise) begin
                            sh  <= rx_word[30:0];
                            cnt <= word_last ? 8'd0 : cnt + 8'd1;
                            // A full word with the previous one unconsumed is dropped
                            if (word_last) begin
                                if (rx_data_valid && !rx_data_ready) begin
                                    overflow <= 1'b1;
                                end else begin
                                    rx_data       <= rx_word;
                                    rx_data_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA_TX: begin
                        if (sclk_rise)
                            cnt <= word_last ? 8'd0 : cnt + 8'd1;
                        if (sclk_fall) begin
                            if (is_quad) begin
                                sdo   <= tx_sh[31:28];
                                tx_sh <= {tx_sh[27:0], 4'h0};
                            end else begin
                                sdo   <= {2'b00, tx_sh[31], 1'b0};
                                tx_sh <= {tx_sh[30:0], 1'b0};
                            end
                        end
                    end
                    default: cnt <= 8'd0;
                endcase
            end

            if (tx_data_ready) begin
                tx_sh <= tx_data_valid ? tx_data : 32'h0;
                if (!tx_data_valid)
                    underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_controller.sv
// Directed and randomized bench for spi_slave_controller acting as
// an SPI master, with a word-level reference of expected traffic.
module tb_spi_slave_controller;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic [3:0]  sdi = 4'h0;
    logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
    logic [3:0]  spi_oe;
    logic [7:0]  cmd;
    logic [31:0] rx_addr;
    logic        rx_addr_valid;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready = 1'b1;
    logic [31:0] tx_data = 32'h0;
    logic        tx_data_valid = 1'b1;
    logic        tx_data_ready;
    logic        eot;
    logic        busy;
    logic        overflow;
    logic        underflow;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int addr_pulses = 0;
    int eot_pulses = 0;
    int txr_pulses = 0;
    logic [31:0] rx_q[$];
    logic [31:0] wr_words[4];
    logic [31:0] rd_words[5];
    logic [3:0]  last_oe;
    logic [3:0]  bit_in;

    spi_slave_controller dut (
        .clk(clk), .rstn(rstn),
        .spi_sclk(spi_sclk), .spi_csn(spi_csn),
        .spi_sdi0(sdi[0]), .spi_sdi1(sdi[1]),
        .spi_sdi2(sdi[2]), .spi_sdi3(sdi[3]),
        .spi_sdo0(spi_sdo0), .spi_sdo1(spi_sdo1),
        .spi_sdo2(spi_sdo2), .spi_sdo3(spi_sdo3),
        .spi_oe(spi_oe), .cmd(cmd),
        .rx_addr(rx_addr), .rx_addr_valid(rx_addr_valid),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .eot(eot), .busy(busy),
        .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_addr_valid) addr_pulses++;
        if (eot) eot_pulses++;
        if (tx_data_ready) txr_pulses++;
        if (rx_data_valid && rx_data_ready) rx_q.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sclk period: present data while low, master samples on rise
    task automatic bit_xfer(input logic [3:0] o, output logic [3:0] i);
        sdi = o;
        wait_clk(HALF);
        spi_sclk = 1'b1;
        i = {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0};
        last_oe = spi_oe;
        wait_clk(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--)
            bit_xfer({3'b000, v[k]}, bit_in);
    endtask

    task automatic send_quad(input logic [31:0] w);
        for (int k = 7; k >= 0; k--)
            bit_xfer(w[k*4 +: 4], bit_in);
    endtask

    task automatic start_txn();
        spi_csn = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_txn();
        wait_clk(HALF);
        spi_csn = 1'b1;
        wait_clk(10);
    endtask

    task automatic do_write(input bit quad, input logic [31:0] addr,
                            input int n);
        int e0, a0;
        e0 = eot_pulses;
        a0 = addr_pulses;
        rx_q.delete();
        start_txn();
        send_bits(quad ? 32'h32 : 32'h02, 8);
        send_bits(addr, 32);
        for (int i = 0; i < n; i++) begin
            if (quad) send_quad(wr_words[i]);
            else send_bits(wr_words[i], 32);
        end
        end_txn();
        chk("wr_cmd", 32'(cmd), quad ? 32'h32 : 32'h02);
        chk("wr_addr_pulses", addr_pulses - a0, 1);
        chk("wr_addr", rx_addr, addr);
        chk("wr_nwords", rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk("wr_word", rx_q[i], wr_words[i]);
        chk("wr_eot", eot_pulses - e0, 1);
        chk("wr_busy", 32'(busy), 0);
    endtask

    task automatic do_read(input bit quad, input logic [31:0] addr,
                           input int n, input bit valid);
        int e0, t0, oe_bad, nbits;
        logic [31:0] w;
        logic [3:0] exp_oe;
        e0 = eot_pulses;
        t0 = txr_pulses;
        tx_data_valid = valid;
        tx_data = rd_words[0];
        exp_oe = quad ? 4'b1111 : 4'b0010;
        nbits = quad ? 8 : 32;
        start_txn();
        send_bits(quad ? 32'h6B : 32'h03, 8);
        send_bits(addr, 32);
        chk("rd_oe_addr", 32'(last_oe), 0);
        for (int d = 0; d < 8; d++)
            bit_xfer(4'h0, bit_in);
        chk("rd_oe_dummy", 32'(last_oe), 0);
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            oe_bad = 0;
            for (int b = 0; b < nbits; b++) begin
                if (b == nbits - 1) tx_data = rd_words[i + 1];
                bit_xfer(4'h0, bit_in);
                w = quad ? {w[27:0], bit_in} : {w[30:0], bit_in[1]};
                if (last_oe !== exp_oe) oe_bad++;
            end
            chk("rd_word", w, valid ? rd_words[i] : 32'h0);
            chk("rd_oe_data", oe_bad, 0);
        end
        end_txn();
        chk("rd_cmd", 32'(cmd), quad ? 32'h6B : 32'h03);
        chk("rd_addr", rx_addr, addr);
        chk("rd_txready_pulses", txr_pulses - t0, n + 1);
        chk("rd_eot", eot_pulses - e0, 1);
        chk("rd_underflow", 32'(underflow), valid ? 32'h0 : 32'h1);
        chk("rd_oe_idle", 32'(spi_oe), 0);
        tx_data_valid = 1'b1;
    endtask

    initial begin
        int a0, e0, t0, bad;
        logic [31:0] addr;

        wait_clk(4);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", 32'(spi_oe), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_addr", rx_addr, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_valids", {29'd0, rx_addr_valid, rx_data_valid, tx_data_ready}, 0);
        chk("rst_flags", {29'd0, eot, overflow, underflow}, 0);
        chk("rst_sdo", {28'd0, spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0}, 0);
        rstn = 1'b1;
        wait_clk(5);

        wr_words[0] = 32'hDEADBEEF;
        wr_words[1] = 32'h12345678;
        do_write(1'b0, 32'h1000_0040, 2);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) wr_words[i] = $urandom;
            do_write(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 3));
        end

        rd_words[0] = 32'hA5C3_0F96;
        for (int i = 1; i < 5; i++) rd_words[i] = $urandom;
        do_read(1'b1, 32'h0, 1, 1'b1);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 5; i++) rd_words[i] = $urandom;
            do_read(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 2), 1'b1);
        end

        for (int i = 0; i < 5; i++) rd_words[i] = $urandom;
        do_read(1'b0, $urandom, 1, 1'b0);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        chk("underflow_clr", 32'(underflow), 0);

        // Quad write of three words with no consumer
        for (int i = 0; i < 4; i++) wr_words[i] = $urandom;
        rx_q.delete();
        rx_data_ready = 1'b0;
        start_txn();
        send_bits(32'h32, 8);
        send_bits($urandom, 32);
        for (int i = 0; i < 3; i++) send_quad(wr_words[i]);
        end_txn();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_hold", rx_data, wr_words[0]);
        chk("ovf_valid", 32'(rx_data_valid), 1);
        rx_data_ready = 1'b1;
        wait_clk(3);
        chk("ovf_drain", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("ovf_word", rx_q[0], wr_words[0]);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        chk("ovf_clr", 32'(overflow), 0);

        // Abort after 12 address bits
        a0 = addr_pulses;
        e0 = eot_pulses;
        addr = $urandom;
        start_txn();
        send_bits(32'h02, 8);
        send_bits({20'd0, addr[31:20]}, 12);
        end_txn();
        chk("abort_addr_pulses", addr_pulses - a0, 0);
        chk("abort_eot", eot_pulses - e0, 1);
        chk("abort_busy", 32'(busy), 0);
        wr_words[0] = $urandom;
        do_write(1'b0, $urandom, 1);

        // Unknown command
        a0 = addr_pulses;
        e0 = eot_pulses;
        t0 = txr_pulses;
        rx_q.delete();
        bad = 0;
        start_txn();
        send_bits(32'h9F, 8);
        for (int i = 0; i < 40; i++) begin
            bit_xfer(4'($urandom), bit_in);
            if (bit_in !== 4'h0 || last_oe !== 4'h0) bad++;
        end
        chk("unk_busy", 32'(busy), 1);
        chk("unk_pads", bad, 0);
        end_txn();
        chk("unk_addr_pulses", addr_pulses - a0, 0);
        chk("unk_rx_words", rx_q.size(), 0);
        chk("unk_txready", txr_pulses - t0, 0);
        chk("unk_eot", eot_pulses - e0, 1);
        chk("unk_busy_end", 32'(busy), 0);

        // Reset in the middle of an address phase
        a0 = addr_pulses;
        start_txn();
        send_bits(32'h02, 8);
        send_bits($urandom, 10);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cmd", 32'(cmd), 0);
        chk("mid_rst_addr", rx_addr, 0);
        wait_clk(3);
        rstn = 1'b1;
        send_bits($urandom, 30);
        chk("mid_rst_ignore", 32'(busy), 1);
        chk("mid_rst_no_addr", addr_pulses - a0, 0);
        end_txn();
        chk("mid_rst_idle", 32'(busy), 0);
        for (int i = 0; i < 4; i++) wr_words[i] = $urandom;
        do_write(1'b1, $urandom, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
